sc_match_scorer: RTL and testbench
==================================

SC_MATCH_SCORER -- requirements
Module: sc_match_scorer

Interface
REQ-001 The block SHALL have parameter PERFECT_WIN, default 16'd2000, the inclusive |dt| bound for grade PERFECT.
REQ-002 The block SHALL have parameter GOOD_WIN, default 16'd5000, the inclusive |dt| bound for grade GOOD.
REQ-003 The block SHALL have parameter OK_WIN, default 16'd10000, the inclusive |dt| bound for grade OK.
REQ-004 The block SHALL have parameters PERFECT_PTS, GOOD_PTS and OK_PTS, defaults 8'd100, 8'd50 and 8'd20, the base points per grade.
REQ-005 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 match_en  input  1  one-cycle pulse; a match result is present.
REQ-008 match_dt  input  16  two's-complement signed song_time minus note_time, in song-clock ticks; valid when match_en=1.
REQ-009 miss_en  input  1  one-cycle pulse; a note scrolled past unhit.
REQ-010 song_restart  input  1  synchronous clear of all scoring state.
REQ-011 grade_valid  output  1  one-cycle pulse; grade is valid.
REQ-012 grade  output  2  hit grade: 3 PERFECT, 2 GOOD, 1 OK, 0 BAD.
REQ-013 miss_pulse  output  1  one-cycle pulse when a miss is applied (miss_en or BAD).
REQ-014 score  output  24  accumulated score.
REQ-015 streak  output  10  current consecutive-hit count.
REQ-016 max_streak  output  10  highest streak reached since reset/restart.
REQ-017 multiplier  output  3  current multiplier, value 1..4.

Function
REQ-018 Stage 1 (edge after input) SHALL register abs_dt = |match_dt|, saturating 16'h8000 to 16'h7FFF, plus registered hit-valid and miss-valid bits.
REQ-019 Stage 2 SHALL classify with inclusive comparisons: abs_dt<=PERFECT_WIN PERFECT; else <=GOOD_WIN GOOD; else <=OK_WIN OK; else BAD.
REQ-020 grade_valid/grade, miss_pulse and all accumulator updates SHALL be visible exactly 2 cycles after the input pulse; the pipeline SHALL accept one event per cycle, back-to-back.
REQ-021 multiplier SHALL be 1 for streak 0-9, 2 for 10-19, 3 for 20-29, 4 for >=30, derived combinationally from the registered streak.
REQ-022 A non-BAD hit SHALL add base_pts*multiplier (multiplier taken from streak before the update) to score and increment streak.
REQ-023 score SHALL saturate at 24'hFFFFFF; streak SHALL saturate at 10'd1023.
REQ-024 A BAD hit SHALL add 0 points, assert grade_valid with grade=0, assert miss_pulse, and clear streak to 0.
REQ-025 A miss_en event SHALL assert miss_pulse, clear streak to 0, and leave grade_valid low.
REQ-026 If match_en and miss_en arrive in the same cycle, the hit SHALL be applied first (points, max_streak updated with the incremented streak), then the miss; the final streak SHALL be 0 and grade_valid and miss_pulse SHALL both pulse.
REQ-027 max_streak SHALL update whenever the new streak exceeds it, in the same cycle as the streak update.
REQ-028 match_dt SHALL be ignored when match_en=0.

Reset
REQ-029 On reset=1 or song_restart=1, all pipeline valid bits, score, streak, max_streak, grade_valid, grade and miss_pulse SHALL clear to 0 on the next edge; multiplier SHALL then read 1.
REQ-030 Events presented in the same cycle as reset/song_restart, or in flight in stage 1/2 at that time, SHALL be discarded.
REQ-031 reset and song_restart SHALL have identical effect; reset takes effect from the first edge it is high.

Verification
REQ-032 match_en with match_dt=16'hF830 (-2000) -> 2 cycles later grade_valid=1, grade=3, score=100, streak=1.
REQ-033 Dt values 2001, 5000, 10000, 10001 on consecutive cycles -> grades 2, 2, 1, 0 on four consecutive cycles; score=120; streak=0; max_streak=3; miss_pulse on the 4th only.
REQ-034 35 PERFECT hits back-to-back -> score=100*10+200*10+300*10+400*5=8000, multiplier=4, streak=35.
REQ-035 match_en (dt=0) and miss_en in the same cycle with streak=9 -> score +100, max_streak=10, streak=0, grade_valid and miss_pulse both pulse.
REQ-036 match_dt=16'h8000 -> grade=0 (no overflow to PERFECT); song_restart asserted 1 cycle after a hit -> that hit discarded, all outputs 0, multiplier=1.

Source files
------------

// File: rtl/sc_match_scorer.sv
// sc_match_scorer
//   Two-stage rhythm-game hit scorer.
//   Stage 1 registers |match_dt| (with -32768 saturated to 32767) and the
//   hit/miss valid bits. Stage 2 grades the hit against the timing windows
//   and updates score, streak and max_streak. All results appear two clock
//   edges after the input pulse, and one event per cycle is accepted.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   match_en     in   1   pulse: match_dt carries a hit timing
//   match_dt     in  16   signed song_time - note_time (ticks)
//   miss_en      in   1   pulse: note passed unhit
//   song_restart in   1   synchronous clear, identical to reset
//   grade_valid  out  1   pulse: grade is valid
//   grade        out  2   3 PERFECT, 2 GOOD, 1 OK, 0 BAD
//   miss_pulse   out  1   pulse when a miss is applied (miss_en or BAD)
//   score        out 24   accumulated score, saturating
//   streak       out 10   consecutive non-BAD hits, saturating
//   max_streak   out 10   highest streak since reset/restart
//   multiplier   out  3   1..4, derived from registered streak
module sc_match_scorer #(
  parameter logic [15:0] PERFECT_WIN = 16'd2000,
  parameter logic [15:0] GOOD_WIN    = 16'd5000,
  parameter logic [15:0] OK_WIN      = 16'd10000,
  parameter logic [7:0]  PERFECT_PTS = 8'd100,
  parameter logic [7:0]  GOOD_PTS    = 8'd50,
  parameter logic [7:0]  OK_PTS      = 8'd20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        match_en,
  input  logic [15:0] match_dt,
  input  logic        miss_en,
  input  logic        song_restart,
  output logic        grade_valid,
  output logic [1:0]  grade,
  output logic        miss_pulse,
  output logic [23:0] score,
  output logic [9:0]  streak,
  output logic [9:0]  max_streak,
  output logic [2:0]  multiplier
);

  typedef enum logic [1:0] {
    GRADE_BAD     = 2'd0,
    GRADE_OK      = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  logic clr;
  assign clr = reset | song_restart;

  // ---------------- stage 1 ----------------
  logic [15:0] abs_dt_d, abs_dt_q;
  logic        hit_v_d, hit_v_q;
  logic        miss_v_d, miss_v_q;

  always_comb begin
    abs_dt_d = '0;
    if (match_en) begin
      if (!match_dt[15])
        abs_dt_d = match_dt;
      else if (match_dt == 16'h8000)
        abs_dt_d = 16'h7FFF;  // -32768 has no positive 16-bit counterpart
      else
        abs_dt_d = ~match_dt + 16'd1;
    end
    hit_v_d  = match_en;
    miss_v_d = miss_en;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      abs_dt_q <= '0;
      hit_v_q  <= 1'b0;
      miss_v_q <= 1'b0;
    end else begin
      abs_dt_q <= abs_dt_d;
      hit_v_q  <= hit_v_d;
      miss_v_q <= miss_v_d;
    end
  end

  // ---------------- stage 2 ----------------
  grade_e      cls;
  logic [7:0]  base_pts;
  logic [2:0]  mult;
  logic [10:0] pts;
  logic [24:0] score_sum;

  grade_e      grade_d, grade_q;
  logic        grade_valid_d, grade_valid_q;
  logic        miss_pulse_d, miss_pulse_q;
  logic [23:0] score_d, score_q;
  logic [9:0]  streak_d, streak_q;
  logic [9:0]  max_streak_d, max_streak_q;

  always_comb begin
    if (abs_dt_q <= PERFECT_WIN)
      cls = GRADE_PERFECT;
    else if (abs_dt_q <= GOOD_WIN)
      cls = GRADE_GOOD;
    else if (abs_dt_q <= OK_WIN)
      cls = GRADE_OK;
    else
      cls = GRADE_BAD;

    case (cls)
      GRADE_PERFECT: base_pts = PERFECT_PTS;
      GRADE_GOOD:    base_pts = GOOD_PTS;
      GRADE_OK:      base_pts = OK_PTS;
      default:       base_pts = '0;
    endcase
  end

  always_comb begin
    if (streak_q >= 10'd30)
      mult = 3'd4;
    else if (streak_q >= 10'd20)
      mult = 3'd3;
    else if (streak_q >= 10'd10)
      mult = 3'd2;
    else
      mult = 3'd1;
  end

  assign pts       = {3'b000, base_pts} * {8'h00, mult};
  assign score_sum = {1'b0, score_q} + {14'h0000, pts};

  always_comb begin
    grade_valid_d = 1'b0;
    grade_d       = GRADE_BAD;
    miss_pulse_d  = 1'b0;
    score_d       = score_q;
    streak_d      = streak_q;
    max_streak_d  = max_streak_q;

    if (hit_v_q) begin
      grade_valid_d = 1'b1;
      grade_d       = cls;
      if (cls != GRADE_BAD) begin
        score_d  = score_sum[24] ? '1 : score_sum[23:0];
        streak_d = (streak_q == '1) ? streak_q : streak_q + 10'd1;
      end else begin
        streak_d     = '0;
        miss_pulse_d = 1'b1;
      end
    end

    // The hit's streak must reach max_streak before a simultaneous miss clears it.
    if (streak_d > max_streak_q)
      max_streak_d = streak_d;

    if (miss_v_q) begin
      miss_pulse_d = 1'b1;
      streak_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      grade_valid_q <= 1'b0;
      grade_q       <= GRADE_BAD;
      miss_pulse_q  <= 1'b0;
      score_q       <= '0;
      streak_q      <= '0;
      max_streak_q  <= '0;
    end else begin
      grade_valid_q <= grade_valid_d;
      grade_q       <= grade_d;
      miss_pulse_q  <= miss_pulse_d;
      score_q       <= score_d;
      streak_q      <= streak_d;
      max_streak_q  <= max_streak_d;
    end
  end

  assign grade_valid = grade_valid_q;
  assign grade       = grade_q;
  assign miss_pulse  = miss_pulse_q;
  assign score       = score_q;
  assign streak      = streak_q;
  assign max_streak  = max_streak_q;
  assign multiplier  = mult;

endmodule

// File: tb/tb_sc_match_scorer.sv
// tb_sc_match_scorer
//   Directed-vector bench for sc_match_scorer with hand-computed expectations.
module tb_sc_match_scorer;

  logic        clk;
  logic        reset;
  logic        match_en;
  logic [15:0] match_dt;
  logic        miss_en;
  logic        song_restart;
  logic        grade_valid;
  logic [1:0]  grade;
  logic        miss_pulse;
  logic [23:0] score;
  logic [9:0]  streak;
  logic [9:0]  max_streak;
  logic [2:0]  multiplier;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sc_match_scorer #(
    .PERFECT_WIN (16'd2000),
    .GOOD_WIN    (16'd5000),
    .OK_WIN      (16'd10000),
    .PERFECT_PTS (8'd100),
    .GOOD_PTS    (8'd50),
    .OK_PTS      (8'd20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .match_en     (match_en),
    .match_dt     (match_dt),
    .miss_en      (miss_en),
    .song_restart (song_restart),
    .grade_valid  (grade_valid),
    .grade        (grade),
    .miss_pulse   (miss_pulse),
    .score        (score),
    .streak       (streak),
    .max_streak   (max_streak),
    .multiplier   (multiplier)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one edge; inputs and outputs are touched 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    match_en     = 1'b0;
    match_dt     = '0;
    miss_en      = 1'b0;
    song_restart = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic restart();
    song_restart = 1'b1;
    step();
    song_restart = 1'b0;
  endtask

  // Single hit, returns after the edge where its result is visible.
  task automatic hit(input logic [15:0] dt);
    match_en = 1'b1;
    match_dt = dt;
    step();
    match_en = 1'b0;
    match_dt = '0;
    step();
  endtask

  logic [15:0] seq_dt    [4] = '{16'd2001, 16'd5000, 16'd10000, 16'd10001};
  logic [1:0]  seq_grade [4] = '{2'd2, 2'd2, 2'd1, 2'd0};
  logic        seq_miss  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [23:0] seq_score [4] = '{24'd50, 24'd100, 24'd120, 24'd120};
  logic [9:0]  seq_strk  [4] = '{10'd1, 10'd2, 10'd3, 10'd0};

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // reset state
    check_eq("rst_gv",    32'(grade_valid), 32'd0);
    check_eq("rst_grade", 32'(grade),       32'd0);
    check_eq("rst_miss",  32'(miss_pulse),  32'd0);
    check_eq("rst_score", 32'(score),       32'd0);
    check_eq("rst_streak",32'(streak),      32'd0);
    check_eq("rst_max",   32'(max_streak),  32'd0);
    check_eq("rst_mult",  32'(multiplier),  32'd1);

    // -2000 is PERFECT, with a two-edge latency
    match_en = 1'b1;
    match_dt = 16'hF830;
    step();
    match_en = 1'b0;
    match_dt = '0;
    check_eq("lat_gv_early", 32'(grade_valid), 32'd0);
    step();
    check_eq("p_gv",     32'(grade_valid), 32'd1);
    check_eq("p_grade",  32'(grade),       32'd3);
    check_eq("p_score",  32'(score),       32'd100);
    check_eq("p_streak", 32'(streak),      32'd1);
    step();
    check_eq("p_gv_pulse", 32'(grade_valid), 32'd0);

    // Window boundaries, back-to-back
    restart();
    check_eq("rs_score", 32'(score), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        match_en = 1'b1;
        match_dt = seq_dt[k];
      end else begin
        match_en = 1'b0;
        match_dt = '0;
      end
      step();
      if (k >= 1) begin
        check_eq($sformatf("win%0d_gv", k - 1),     32'(grade_valid), 32'd1);
        check_eq($sformatf("win%0d_grade", k - 1),  32'(grade),       32'(seq_grade[k-1]));
        check_eq($sformatf("win%0d_miss", k - 1),   32'(miss_pulse),  32'(seq_miss[k-1]));
        check_eq($sformatf("win%0d_score", k - 1),  32'(score),       32'(seq_score[k-1]));
        check_eq($sformatf("win%0d_streak", k - 1), 32'(streak),      32'(seq_strk[k-1]));
      end
    end
    check_eq("win_max", 32'(max_streak), 32'd3);

    // 35 PERFECT hits back-to-back: multiplier steps at 10/20/30
    restart();
    for (int k = 0; k <= 35; k++) begin
      match_en = (k < 35);
      match_dt = '0;
      step();
      case (k)
        9:  begin check_eq("run9_score",  32'(score), 32'd900);  check_eq("run9_mult",  32'(multiplier), 32'd1); end
        10: begin check_eq("run10_score", 32'(score), 32'd1000); check_eq("run10_mult", 32'(multiplier), 32'd2); end
        11: check_eq("run11_score", 32'(score), 32'd1200);
        20: begin check_eq("run20_score", 32'(score), 32'd3000); check_eq("run20_mult", 32'(multiplier), 32'd3); end
        21: check_eq("run21_score", 32'(score), 32'd3300);
        30: begin check_eq("run30_score", 32'(score), 32'd6000); check_eq("run30_mult", 32'(multiplier), 32'd4); end
        default: ;
      endcase
    end
    match_en = 1'b0;
    check_eq("run_score",  32'(score),      32'd8000);
    check_eq("run_mult",   32'(multiplier), 32'd4);
    check_eq("run_streak", 32'(streak),     32'd35);
    check_eq("run_max",    32'(max_streak), 32'd35);

    // Simultaneous hit and miss at streak 9
    restart();
    for (int k = 0; k < 9; k++) hit(16'd0);
    check_eq("hm_pre_streak", 32'(streak), 32'd9);
    match_en = 1'b1;
    match_dt = 16'd0;
    miss_en  = 1'b1;
    step();
    match_en = 1'b0;
    miss_en  = 1'b0;
    step();
    check_eq("hm_gv",     32'(grade_valid), 32'd1);
    check_eq("hm_grade",  32'(grade),       32'd3);
    check_eq("hm_miss",   32'(miss_pulse),  32'd1);
    check_eq("hm_score",  32'(score),       32'd1000);
    check_eq("hm_max",    32'(max_streak),  32'd10);
    check_eq("hm_streak", 32'(streak),      32'd0);

    // Plain miss
    hit(16'd1500);
    check_eq("m_pre_score", 32'(score), 32'd1100);
    miss_en = 1'b1;
    step();
    miss_en = 1'b0;
    step();
    check_eq("m_gv",     32'(grade_valid), 32'd0);
    check_eq("m_miss",   32'(miss_pulse),  32'd1);
    check_eq("m_streak", 32'(streak),      32'd0);
    check_eq("m_score",  32'(score),       32'd1100);
    check_eq("m_max",    32'(max_streak),  32'd10);

    // Extreme dt values and a late-window negative value
    hit(16'h8000);
    check_eq("x8000_gv",    32'(grade_valid), 32'd1);
    check_eq("x8000_grade", 32'(grade),       32'd0);
    check_eq("x8000_miss",  32'(miss_pulse),  32'd1);
    hit(16'h7FFF);
    check_eq("x7fff_grade", 32'(grade), 32'd0);
    hit(16'hF82F);
    check_eq("n2001_grade", 32'(grade), 32'd2);
    check_eq("n2001_score", 32'(score), 32'd1150);

    // match_dt without match_en is ignored
    match_dt = 16'd0;
    step();
    match_dt = '0;
    step();
    check_eq("noen_gv",    32'(grade_valid), 32'd0);
    check_eq("noen_score", 32'(score),       32'd1150);

    // Restart one cycle after a hit discards it
    match_en = 1'b1;
    match_dt = 16'd0;
    step();
    match_en     = 1'b0;
    song_restart = 1'b1;
    step();
    song_restart = 1'b0;
    check_eq("rsf_gv",     32'(grade_valid), 32'd0);
    check_eq("rsf_score",  32'(score),       32'd0);
    check_eq("rsf_streak", 32'(streak),      32'd0);
    check_eq("rsf_max",    32'(max_streak),  32'd0);
    check_eq("rsf_mult",   32'(multiplier),  32'd1);
    step();
    check_eq("rsf_gv_after", 32'(grade_valid), 32'd0);
    check_eq("rsf_score_after", 32'(score), 32'd0);

    // Event in the same cycle as reset is dropped
    match_en = 1'b1;
    match_dt = 16'd0;
    reset    = 1'b1;
    step();
    match_en = 1'b0;
    reset    = 1'b0;
    step();
    step();
    check_eq("rsc_gv",    32'(grade_valid), 32'd0);
    check_eq("rsc_score", 32'(score),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
